noc_periph_responder: RTL and testbench

//  Target-side responder on the router's peripheral port. Accepts one request at a time
//  (req/we/addr/wdata held until ack) and returns rdata/ack/error.

---
 rtl/noc_periph_responder.sv | 160 ++++++++++++++++
 tb/tb_noc_periph_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_periph_responder.sv
// noc_periph_responder: target-side responder on the router's peripheral port.
// Takes one held request at a time, decodes the peripheral window into fixed-size
// slots and runs a single APB-style 32-bit access, returning rdata/ack/error.
// Optional feature macro: NOC_PERIPH_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES).
module noc_periph_responder #(
  parameter int unsigned           DATA_WIDTH     = 128,
  parameter int unsigned           ADDR_WIDTH     = 56,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE    = 56'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_SIZE    = 56'h1000_0000,
  parameter int unsigned           NUM_SLOTS      = 8,
  parameter int unsigned           SLOT_SHIFT     = 16,
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_in,
  input  logic                      we_in,
  input  logic [ADDR_WIDTH-1:0]     addr_in,
  input  logic [DATA_WIDTH-1:0]     wdata_in,
  output logic [DATA_WIDTH-1:0]     rdata_out,
  output logic                      ack_out,
  output logic                      error_out,
  output logic [NUM_SLOTS-1:0]      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [SLOT_SHIFT-1:0]     paddr,
  output logic [31:0]               pwdata,
  input  logic [NUM_SLOTS*32-1:0]   prdata,
  input  logic [NUM_SLOTS-1:0]      pready,
  input  logic [NUM_SLOTS-1:0]      pslverr
);

  localparam int unsigned LANES = DATA_WIDTH / 32;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_SLOTS_A = ADDR_WIDTH'(NUM_SLOTS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]            state;
  logic [SW-1:0]         slot_q;
  logic [LW-1:0]         lane_q;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] offset;
  logic [SW-1:0]         slot_d;
  logic [LW-1:0]         lane_d;
  logic                  decode_ok;
  logic [DATA_WIDTH-1:0] rd_lane;

`ifdef NOC_PERIPH_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
`endif

  // Window/slot/alignment decode of the incoming address; slot comes from the offset.
  always_comb begin
    offset    = addr_in - PERIPH_BASE;
    slot_d    = offset[SLOT_SHIFT +: SW];
    lane_d    = (LANES > 1) ? addr_in[2 +: LW] : '0;
    decode_ok = (addr_in >= PERIPH_BASE) && (offset < PERIPH_SIZE) &&
                ((offset >> SLOT_SHIFT) < NUM_SLOTS_A) && (addr_in[1:0] == 2'b00);
  end

  // Place the selected slot's read word into its lane; all other lanes zero.
  always_comb begin
    rd_lane = '0;
    rd_lane[32*int'(lane_q) +: 32] = prdata[32*int'(slot_q) +: 32];
  end

  // Request FSM and registered APB/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      slot_q    <= '0;
      lane_q    <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      rdata_out <= '0;
      ack_out   <= 1'b0;
      error_out <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
`ifdef NOC_PERIPH_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      ack_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_in) begin
            slot_q <= slot_d;
            lane_q <= lane_d;
            pwrite <= we_in;
            if (decode_ok) begin
              psel    <= NUM_SLOTS'(1) << slot_d;
              penable <= 1'b0;
              paddr   <= addr_in[SLOT_SHIFT-1:0];
              pwdata  <= wdata_in[32*int'(lane_d) +: 32];
              state   <= S_SETUP;
            end else begin
              resp_err  <= 1'b1;
              resp_data <= '0;
              state     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
`ifdef NOC_PERIPH_TIMEOUT_EN
          to_cnt  <= '0;
`endif
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready is tested first so it wins over a coinciding timeout.
          if (pready[slot_q]) begin
            psel      <= '0;
            penable   <= 1'b0;
            resp_err  <= pslverr[slot_q];
            resp_data <= pwrite ? '0 : rd_lane;
            state     <= S_RESP;
          end
`ifdef NOC_PERIPH_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            psel      <= '0;
            penable   <= 1'b0;
            resp_err  <= 1'b1;
            resp_data <= '0;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`else
          // No abort path: ACCESS waits for pready indefinitely.
`endif
        end
        S_RESP: begin
          ack_out   <= 1'b1;
          rdata_out <= resp_data;
          error_out <= resp_err;
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!req_in) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_periph_responder.sv
// Self-checking bench for noc_periph_responder: directed cases plus randomized
// transactions checked against a spec-level reference model.
module tb_noc_periph_responder;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 56;
  localparam int unsigned NS = 8;
  localparam int unsigned SS = 16;
  localparam int unsigned TO = 4;
  localparam longint unsigned BASE = 64'h4000_0000;
  localparam longint unsigned SIZE = 64'h1000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_in;
  logic             we_in;
  logic [AW-1:0]    addr_in;
  logic [DW-1:0]    wdata_in;
  logic [DW-1:0]    rdata_out;
  logic             ack_out;
  logic             error_out;
  logic [NS-1:0]    psel;
  logic             penable;
  logic             pwrite;
  logic [SS-1:0]    paddr;
  logic [31:0]      pwdata;
  logic [NS*32-1:0] prdata;
  logic [NS-1:0]    pready;
  logic [NS-1:0]    pslverr;

  int checks   = 0;
  int failures = 0;
  int setup_cnt = 0;

  noc_periph_responder #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .NUM_SLOTS     (NS),
    .SLOT_SHIFT    (SS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .we_in    (we_in),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
    .rdata_out(rdata_out),
    .ack_out  (ack_out),
    .error_out(error_out),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  // Count APB setup phases to detect re-issued accesses.
  always @(posedge clk) if (!rst && psel != '0 && !penable) setup_cnt <= setup_cnt + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the window/slot/alignment rules.
  function automatic bit model_ok(input longint unsigned a);
    if (a < BASE || a >= BASE + SIZE) return 1'b0;
    if (((a - BASE) / 65536) >= NS) return 1'b0;
    if (a % 4 != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdata"}, rdata_out, '0);
    chk({tag, "_ctl"}, DW'({ack_out, error_out, psel, penable, pwrite, paddr, pwdata}), '0);
  endtask

  // One complete request: drive, watch APB phases, check ack latency and response.
  task automatic txn(input string tag, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input int waits, input bit slverr,
                     input int hold, input logic [31:0] sel_word);
    bit ok;
    int slot, lane, kack, exp_k, s0;
    logic [DW-1:0] exp_rd, shifted;
    ok   = model_ok(longint'(a));
    slot = ok ? int'((longint'(a) - BASE) / 65536) : 0;
    lane = int'((longint'(a) / 4) % 4);
    for (int s = 0; s < NS; s++) prdata[s*32 +: 32] = $urandom;
    prdata[slot*32 +: 32] = sel_word;
    pready  = NS'($urandom);
    pslverr = NS'($urandom);
    if (ok) begin
      pready[slot]  = 1'b0;
      pslverr[slot] = slverr;
    end
    exp_rd  = (!ok || we) ? '0 : (DW'(sel_word) << (32 * lane));
    shifted = wd >> (32 * lane);
    exp_k   = ok ? waits + 3 : 1;
    s0      = setup_cnt;
    req_in = 1'b1; we_in = we; addr_in = a; wdata_in = wd;
    kack = -1;
    for (int k = 0; k < waits + 12 && kack < 0; k++) begin
      cycle();
      if (k == 0) begin
        if (ok) begin
          chk({tag, "_setup_psel"}, DW'(psel), DW'(NS'(1) << slot));
          chk({tag, "_setup_pen"}, DW'(penable), '0);
          chk({tag, "_pwrite"}, DW'(pwrite), DW'(we));
          chk({tag, "_paddr"}, DW'(paddr), DW'(longint'(a) % 65536));
          chk({tag, "_pwdata"}, DW'(pwdata), DW'(shifted[31:0]));
        end else begin
          chk({tag, "_nopsel"}, DW'(psel), '0);
        end
      end
      if (ok && k == 1) chk({tag, "_access"}, DW'({psel, penable}), DW'({NS'(1) << slot, 1'b1}));
      if (ok) pready[slot] = (k == waits + 1);
      if (ack_out) kack = k;
    end
    chk({tag, "_latency"}, DW'(kack), DW'(exp_k));
    chk({tag, "_error"}, DW'(error_out), DW'(ok ? slverr : 1'b1));
    chk({tag, "_rdata"}, rdata_out, exp_rd);
    chk({tag, "_apb_idle"}, DW'({psel, penable}), '0);
    for (int h = 0; h < hold; h++) begin
      cycle();
      chk({tag, "_hold_noack"}, DW'(ack_out), '0);
    end
    req_in = 1'b0;
    pready = '0;
    cycle();
    chk({tag, "_drain_noack"}, DW'(ack_out), '0);
    chk({tag, "_rdata_held"}, rdata_out, exp_rd);
    chk({tag, "_accesses"}, DW'(setup_cnt - s0), DW'(ok ? 1 : 0));
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int kind, kack, exp_k, limit;

    rst = 1'b1; req_in = 1'b0; we_in = 1'b0; addr_in = '0; wdata_in = '0;
    prdata = '0; pready = '0; pslverr = '0;
    @(negedge clk);
    repeat (3) cycle();
    check_reset_outputs("reset");
    rst = 1'b0;
    cycle();

    // Directed cases
    txn("t1_read", 1'b0, 56'h4001_0008, '0, 0, 1'b0, 0, 32'hDEAD_BEEF);
    wd = {$urandom, $urandom, $urandom, $urandom};
    wd[63:32] = 32'h1234_5678;
    txn("t2_write", 1'b1, 56'h4000_0004, wd, 2, 1'b0, 0, $urandom);
    txn("t3_below", 1'b0, 56'h3FFF_FFFC, '0, 0, 1'b0, 0, $urandom);
    txn("t3_above", 1'b0, 56'h5000_0000, '0, 0, 1'b0, 0, $urandom);
    txn("t3_slot8", 1'b0, 56'h4008_0000, '0, 0, 1'b0, 0, $urandom);
    txn("t3_misal", 1'b1, 56'h4000_0002, '0, 0, 1'b0, 0, $urandom);
    txn("t4_slverr", 1'b0, 56'h4007_0010, '0, 0, 1'b1, 4, $urandom);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        0: a = AW'({$urandom, $urandom});
        1: a = AW'(BASE + (longint'($urandom_range(8, 4095)) << 16));
        2: a = AW'(BASE + (longint'($urandom_range(0, 7)) << 16) + longint'($urandom_range(1, 3)));
        default: a = AW'(BASE + (longint'($urandom_range(0, 7)) << 16) +
                         (longint'($urandom_range(0, 16383)) << 2));
      endcase
      wd = {$urandom, $urandom, $urandom, $urandom};
      txn("rand", 1'($urandom), a, wd, int'($urandom_range(0, 3)), 1'($urandom),
          int'($urandom_range(0, 2)), $urandom);
    end

    // Stuck slave on slot 2 (other slots claim ready, which must be ignored)
`ifdef NOC_PERIPH_TIMEOUT_EN
    limit = 50;
    exp_k = TO + 2;
`else
    limit = 1000;
    exp_k = -1;
`endif
    pready = 8'hFB; pslverr = '0;
    req_in = 1'b1; we_in = 1'b0; addr_in = 56'h4002_0000;
    kack = -1;
    for (int k = 0; k < limit && kack < 0; k++) begin
      cycle();
      if (ack_out) kack = k;
    end
    chk("stuck_ack", DW'(kack), DW'(exp_k));
`ifdef NOC_PERIPH_TIMEOUT_EN
    chk("timeout_err", DW'(error_out), DW'(1));
    chk("timeout_rdata", rdata_out, '0);
    chk("timeout_psel", DW'({psel, penable}), '0);
    req_in = 1'b0;
    cycle();
`else
    rst = 1'b1; req_in = 1'b0;
    cycle();
    check_reset_outputs("rst_stuck");
    rst = 1'b0;
    cycle();
`endif

    // Reset while in ACCESS, then a normal transaction
    pready = '0;
    req_in = 1'b1; we_in = 1'b1; addr_in = 56'h4003_0100; wdata_in = '1;
    cycle();
    cycle();
    chk("pre_rst_access", DW'(penable), DW'(1));
    rst = 1'b1; req_in = 1'b0;
    cycle();
    check_reset_outputs("rst_access");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("post_rst_noack", DW'(ack_out), '0);
    end
    txn("after_rst", 1'b0, 56'h4005_000C, '0, 1, 1'b0, 0, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
